// File: rtl/riscv_ctrl_bpred_if.sv
// riscv_ctrl_bpred_if
//   Groups the fetch-side lookup, execute-side training and prediction
//   outputs of the branch predictor into one bundle.
//   master : pipeline side (drives fetch PC, flush and resolution updates,
//            receives predictions)
//   slave  : predictor side
//   Signals:
//     ivalid_f / ipc_f / iflush            fetch lookup request and flush
//     iupd_valid / iupd_pc / iupd_is_b /
//     iupd_is_j / iupd_taken / iupd_target resolution update from execute
//     opred_valid / opred_taken /
//     opred_target / ohit                  registered prediction
interface riscv_ctrl_bpred_if #(
  parameter int P_XLEN = 32
);
  logic              ivalid_f;
  logic [P_XLEN-1:0] ipc_f;
  logic              iflush;
  logic              iupd_valid;
  logic [P_XLEN-1:0] iupd_pc;
  logic              iupd_is_b;
  logic              iupd_is_j;
  logic              iupd_taken;
  logic [P_XLEN-1:0] iupd_target;
  logic              opred_valid;
  logic              opred_taken;
  logic [P_XLEN-1:0] opred_target;
  logic              ohit;

  modport master (
    output ivalid_f, ipc_f, iflush,
    output iupd_valid, iupd_pc, iupd_is_b, iupd_is_j, iupd_taken, iupd_target,
    input  opred_valid, opred_taken, opred_target, ohit
  );

  modport slave (
    input  ivalid_f, ipc_f, iflush,
    input  iupd_valid, iupd_pc, iupd_is_b, iupd_is_j, iupd_taken, iupd_target,
    output opred_valid, opred_taken, opred_target, ohit
  );
endinterface

// File: rtl/riscv_ctrl_bpred.sv
// riscv_ctrl_bpred
//   Direct-mapped branch predictor / BTB for the fetch stage. Each cycle the
//   fetch PC is looked up and a registered prediction (redirect flag and next
//   PC) is presented one cycle later. Resolved branches and jumps from execute
//   train the table with a 2-bit saturating counter per entry.
//   Ports:
//     iclk    clock, all state on the rising edge
//     irst_n  asynchronous active-low reset
//     bus     riscv_ctrl_bpred_if.slave (lookup, update and prediction)
module riscv_ctrl_bpred #(
  parameter int P_XLEN    = 32,
  parameter int P_ENTRIES = 16
) (
  input  logic               iclk,
  input  logic               irst_n,
  riscv_ctrl_bpred_if.slave  bus
);
  localparam int IDXW = $clog2(P_ENTRIES);
  localparam int TAGW = P_XLEN - IDXW - 2;

  // Table state. Reset clears every entry, so this is register storage.
  logic              valid_q  [P_ENTRIES];
  logic [TAGW-1:0]   tag_q    [P_ENTRIES];
  logic [P_XLEN-1:0] target_q [P_ENTRIES];
  logic [1:0]        ctr_q    [P_ENTRIES];

  // Output registers
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic              hit_q, hit_d;
  logic [P_XLEN-1:0] pred_target_q, pred_target_d;

  // Lookup side
  logic [IDXW-1:0]   lk_idx;
  logic [TAGW-1:0]   lk_tag;

  // Update side
  logic              upd_en;
  logic              upd_hit;
  logic [IDXW-1:0]   upd_idx;
  logic [TAGW-1:0]   upd_tag;
  logic [1:0]        ent_ctr_d;
  logic [P_XLEN-1:0] ent_target_d;

  // PC bits [1:0] are always zero and carry no information.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.ipc_f[1:0], bus.iupd_pc[1:0]};

  assign lk_idx  = bus.ipc_f[IDXW+1:2];
  assign lk_tag  = bus.ipc_f[P_XLEN-1:IDXW+2];
  assign upd_idx = bus.iupd_pc[IDXW+1:2];
  assign upd_tag = bus.iupd_pc[P_XLEN-1:IDXW+2];
  assign upd_en  = bus.iupd_valid && (bus.iupd_is_b || bus.iupd_is_j);

  // Lookup reads the current (pre-update) table contents: no bypass from a
  // same-cycle update.
  always_comb begin
    hit_d         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_d  = hit_d && ctr_q[lk_idx][1];
    pred_target_d = pred_taken_d ? target_q[lk_idx]
                                 : bus.ipc_f + P_XLEN'(4);
    pred_valid_d  = bus.ivalid_f && !bus.iflush;
  end

  // Next contents of the entry being trained.
  always_comb begin
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    ent_ctr_d    = ctr_q[upd_idx];
    ent_target_d = target_q[upd_idx];
    if (bus.iupd_is_j) begin
      // Jumps always redirect: install as strongly taken.
      ent_ctr_d    = 2'b11;
      ent_target_d = bus.iupd_target;
    end else if (!upd_hit) begin
      // Branch allocation evicts whatever was there, starting weak.
      ent_ctr_d    = bus.iupd_taken ? 2'b10 : 2'b01;
      ent_target_d = bus.iupd_target;
    end else if (bus.iupd_taken) begin
      if (ctr_q[upd_idx] != 2'b11) ent_ctr_d = ctr_q[upd_idx] + 2'b01;
      ent_target_d = bus.iupd_target;
    end else begin
      // Not-taken keeps the old target so a later re-take reuses it.
      if (ctr_q[upd_idx] != 2'b00) ent_ctr_d = ctr_q[upd_idx] - 2'b01;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      for (int i = 0; i < P_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= ent_target_d;
      ctr_q[upd_idx]    <= ent_ctr_d;
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      hit_q         <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      hit_q         <= hit_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign bus.opred_valid  = pred_valid_q;
  assign bus.opred_taken  = pred_taken_q;
  assign bus.opred_target = pred_target_q;
  assign bus.ohit         = hit_q;
endmodule

// File: tb/tb_riscv_ctrl_bpred.sv
// tb_riscv_ctrl_bpred
//   Drives lookups/updates on the falling edge, pushes the expected
//   prediction into a scoreboard queue, and pops/compares it on the
//   following falling edge once the registered outputs have settled.
module tb_riscv_ctrl_bpred;
  typedef struct packed {
    logic        v;
    logic        h;
    logic        t;
    logic [31:0] tgt;
  } exp_t;

  logic iclk;
  logic irst_n;
  int   errors;
  int   checks;
  exp_t exp_q [$];
  string name_q [$];

  riscv_ctrl_bpred_if #(.P_XLEN(32)) bus ();

  riscv_ctrl_bpred #(.P_XLEN(32), .P_ENTRIES(16)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive lookup + update, expect prediction after the edge.
  task automatic cyc(input string name, input logic vf, input logic [31:0] pc,
                     input logic fl, input logic uv, input logic [31:0] upc,
                     input logic ub, input logic uj, input logic ut,
                     input logic [31:0] utgt, input exp_t e);
    exp_t  got_e;
    string nm;
    bus.ivalid_f    = vf;
    bus.ipc_f       = pc;
    bus.iflush      = fl;
    bus.iupd_valid  = uv;
    bus.iupd_pc     = upc;
    bus.iupd_is_b   = ub;
    bus.iupd_is_j   = uj;
    bus.iupd_taken  = ut;
    bus.iupd_target = utgt;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge iclk);
    @(negedge iclk);
    got_e = exp_q.pop_front();
    nm    = name_q.pop_front();
    check({nm, ".valid"},  32'(bus.opred_valid), 32'(got_e.v));
    check({nm, ".hit"},    32'(bus.ohit),        32'(got_e.h));
    check({nm, ".taken"},  32'(bus.opred_taken), 32'(got_e.t));
    check({nm, ".target"}, bus.opred_target,     got_e.tgt);
    $display("txn %-14s pc=0x%08h upd=%0b@0x%08h -> v=%0b h=%0b t=%0b tgt=0x%08h",
             nm, pc, uv, upc, bus.opred_valid, bus.ohit, bus.opred_taken, bus.opred_target);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input exp_t e);
    cyc(name, 1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e);
  endtask

  // Update only; fetch idle at PC 0 which never hits in this sequence.
  task automatic upd(input string name, input logic [31:0] upc, input logic ub,
                     input logic uj, input logic ut, input logic [31:0] utgt);
    cyc(name, 1'b0, 32'h0, 1'b0, 1'b1, upc, ub, uj, ut, utgt, '{1'b0, 1'b0, 1'b0, 32'h4});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    irst_n = 1'b0;
    bus.ivalid_f = 1'b0; bus.ipc_f = '0; bus.iflush = 1'b0;
    bus.iupd_valid = 1'b0; bus.iupd_pc = '0; bus.iupd_is_b = 1'b0;
    bus.iupd_is_j = 1'b0; bus.iupd_taken = 1'b0; bus.iupd_target = '0;
    #12;
    check("rst.valid",  32'(bus.opred_valid), 32'h0);
    check("rst.hit",    32'(bus.ohit),        32'h0);
    check("rst.taken",  32'(bus.opred_taken), 32'h0);
    check("rst.target", bus.opred_target,     32'h0);
    @(negedge iclk);
    irst_n = 1'b1;

    look("miss_100", 32'h100, '{1'b1, 1'b0, 1'b0, 32'h104});

    // Branch training and counter saturation at 0x200
    upd("b200_T", 32'h200, 1'b1, 1'b0, 1'b1, 32'h180);
    look("hit_200", 32'h200, '{1'b1, 1'b1, 1'b1, 32'h180});
    cyc("b200_NT1", 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h999,
        '{1'b1, 1'b1, 1'b1, 32'h180});
    cyc("b200_NT2", 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h999,
        '{1'b1, 1'b1, 1'b0, 32'h204});
    cyc("b200_NT3", 1'b1, 32'h200, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h999,
        '{1'b1, 1'b1, 1'b0, 32'h204});
    look("nt_200", 32'h200, '{1'b1, 1'b1, 1'b0, 32'h204});
    // One taken from 00 reaches only 01: still predicted not taken.
    upd("b200_T_again", 32'h200, 1'b1, 1'b0, 1'b1, 32'h188);
    look("weak_200", 32'h200, '{1'b1, 1'b1, 1'b0, 32'h204});

    // JAL install (taken flag ignored) and alias eviction
    upd("jal_300", 32'h300, 1'b0, 1'b1, 1'b0, 32'h1000);
    look("hit_300", 32'h300, '{1'b1, 1'b1, 1'b1, 32'h1000});
    cyc("b340_NT", 1'b1, 32'h300, 1'b0, 1'b1, 32'h340, 1'b1, 1'b0, 1'b0, 32'h2000,
        '{1'b1, 1'b1, 1'b1, 32'h1000});
    look("evict_300", 32'h300, '{1'b1, 1'b0, 1'b0, 32'h304});
    look("wnt_340", 32'h340, '{1'b1, 1'b1, 1'b0, 32'h344});

    // Update of an unrelated valid-less op must not touch the table
    cyc("noop_upd", 1'b0, 32'h0, 1'b0, 1'b1, 32'h340, 1'b0, 1'b0, 1'b1, 32'h3000,
        '{1'b0, 1'b0, 1'b0, 32'h4});
    look("still_340", 32'h340, '{1'b1, 1'b1, 1'b0, 32'h344});

    // Same-cycle lookup/update, no bypass
    cyc("same_400", 1'b1, 32'h400, 1'b0, 1'b1, 32'h400, 1'b1, 1'b0, 1'b1, 32'h800,
        '{1'b1, 1'b0, 1'b0, 32'h404});
    look("hit_400", 32'h400, '{1'b1, 1'b1, 1'b1, 32'h800});

    // Flush kills valid only
    cyc("flush_400", 1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,
        '{1'b0, 1'b1, 1'b1, 32'h800});

    // Wrap-around fall-through target
    look("wrap_top", 32'hFFFF_FFFC, '{1'b1, 1'b0, 1'b0, 32'h0});

    // Mid-stream async reset with an update pending
    look("pre_rst_400", 32'h400, '{1'b1, 1'b1, 1'b1, 32'h800});
    #1;
    bus.iupd_valid = 1'b1; bus.iupd_pc = 32'h500; bus.iupd_is_b = 1'b0;
    bus.iupd_is_j = 1'b1; bus.iupd_target = 32'h5000;
    irst_n = 1'b0;
    #1;
    check("arst.valid",  32'(bus.opred_valid), 32'h0);
    check("arst.hit",    32'(bus.ohit),        32'h0);
    check("arst.taken",  32'(bus.opred_taken), 32'h0);
    check("arst.target", bus.opred_target,     32'h0);
    @(negedge iclk);
    irst_n = 1'b1;
    look("post_rst_400", 32'h400, '{1'b1, 1'b0, 1'b0, 32'h404});
    look("post_rst_500", 32'h500, '{1'b1, 1'b0, 1'b0, 32'h504});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
